// File: rtl/spike_shift_arbiter.sv
// Round-robin arbiter that time-shares one external barrel shifter among NUM_REQ
// requesters: accept, issue one cycle to the shifter, return the registered result.
module spike_shift_arbiter #(
    parameter  int NUM_REQ       = 4,
    parameter  int LEN           = 8,
    parameter  int MAX_SHIFT_MAG = 2,
    localparam int SW            = 2 * MAX_SHIFT_MAG + 1,
    localparam int ID_W          = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*LEN-1:0] req_data,
    input  logic [NUM_REQ*SW-1:0]  req_shift,
    output logic [LEN-1:0]         sh_ip,
    output logic [SW-1:0]          sh_shift_mag,
    input  logic [LEN-1:0]         sh_op,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [LEN-1:0]         rsp_data,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   rsp_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] id_reg;
    logic            err_reg;

    logic            grant_any;
    logic [ID_W-1:0] grant_id;
    logic [LEN-1:0]  sel_data;
    logic [SW-1:0]   sel_shift;
    logic            sel_err;
    logic            accept;
    int unsigned     idx;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        idx       = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = (32'(rr_ptr) + off) % NUM_REQ;
            if (!grant_any && req_valid[ID_W'(idx)]) begin
                grant_any = 1'b1;
                grant_id  = ID_W'(idx);
            end
        end
    end

    always_comb begin
        sel_data  = '0;
        sel_shift = '0;
        for (int unsigned r = 0; r < NUM_REQ; r++) begin
            if (grant_id == ID_W'(r)) begin
                sel_data  = req_data[r*LEN +: LEN];
                sel_shift = req_shift[r*SW +: SW];
            end
        end
    end

    // More than one bit set iff clearing the lowest set bit leaves something.
    assign sel_err = |(sel_shift & (sel_shift - SW'(1)));

    assign accept = (state == IDLE) && grant_any && !rst;

    always_comb begin
        req_ready = '0;
        for (int unsigned r = 0; r < NUM_REQ; r++) begin
            req_ready[r] = accept && (grant_id == ID_W'(r));
        end
    end

    // sh_ip/sh_shift_mag double as the latched operand and shift code: loaded on
    // accept, presented during ISSUE, cleared on leaving ISSUE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            id_reg       <= '0;
            err_reg      <= 1'b0;
            sh_ip        <= '0;
            sh_shift_mag <= '0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_id       <= '0;
            rsp_err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        sh_ip        <= sel_data;
                        sh_shift_mag <= sel_shift;
                        id_reg       <= grant_id;
                        err_reg      <= sel_err;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    rsp_data     <= sh_op;
                    rsp_id       <= id_reg;
                    rsp_err      <= err_reg;
                    rsp_valid    <= 1'b1;
                    sh_ip        <= '0;
                    sh_shift_mag <= '0;
                    state        <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rr_ptr    <= (id_reg == ID_W'(NUM_REQ - 1)) ? '0 : id_reg + ID_W'(1);
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/spike_shift_arbiter.md
Name: spike_shift_arbiter

Overview:
Round-robin arbiter and sequencer that shares one mux-based barrel shifter (thermometer/one-hot shift, LEN-bit spike vectors) among NUM_REQ requesters. It accepts one request per transaction, drives the shared shifter's operand and shift-magnitude lines for exactly one cycle, and registers the shifted result. It returns the result on a valid/ready response channel, tagged with the requester ID. It sits between spike-volley producers, such as column/neuron units, and a single shifter instance that is external to this block.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
LEN, 8, spike vector width; must match the shifter's LEN
MAX_SHIFT_MAG, 2, max shift magnitude; shift field width SW = 2*MAX_SHIFT_MAG+1
ID_W, $clog2(NUM_REQ), width of the requester ID (derived, not overridden)

Ports:
clk  in  1  clock
rst  in  1  reset: one clock; reset is synchronous and active-high
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept strobe (one-hot or zero)
req_data  in  NUM_REQ*LEN  flattened spike vectors; requester r occupies bits [r*LEN +: LEN]
req_shift  in  NUM_REQ*SW  flattened one-hot shift codes; requester r occupies bits [r*SW +: SW]
sh_ip  out  LEN  operand to the shared shifter
sh_shift_mag  out  SW  shift code to the shared shifter
sh_op  in  LEN  shifter result (combinational from sh_ip/sh_shift_mag)
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_data  out  LEN  registered shifted vector
rsp_id  out  ID_W  requester index of the response
rsp_err  out  1  shift code had more than one bit set

Behaviour:
- FSM states: IDLE, ISSUE, RESP. Registers: state, rr_ptr, op_reg, sh_reg, id_reg, err_reg, rsp_data, rsp_valid.
- Reset (sync, active-high, wins over all other events):
  - state=IDLE, rr_ptr=0.
  - rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0.
  - sh_ip=0, sh_shift_mag=0, req_ready=0.
  - A reset mid-transaction drops the transaction with no response.
- IDLE:
  - Grant g = first r with req_valid[r]=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[g]=1 combinationally in that same cycle; this is the accept handshake.
  - On the clock edge: latch op_reg, sh_reg, id_reg=g, err_reg; go to ISSUE.
  - No valid requests: stay in IDLE with req_ready=0.
- req_ready is 0 in every state except IDLE. It is never asserted for a requester whose req_valid=0.
- ISSUE (exactly 1 cycle):
  - sh_ip=op_reg and sh_shift_mag=sh_reg.
  - On the edge: rsp_data<=sh_op, rsp_id<=id_reg, rsp_err<=err_reg, rsp_valid<=1; go to RESP.
- Outside ISSUE: sh_ip=0 and sh_shift_mag=0 (no shift, zero operand). Both are driven from registers/state only, so there is no combinational path from req_* to sh_*.
- RESP:
  - rsp_valid, rsp_data, rsp_id and rsp_err are held stable while rsp_ready=0.
  - On rsp_valid&&rsp_ready: rsp_valid<=0, rr_ptr<=(id_reg+1) mod NUM_REQ, go to IDLE.
  - There is no bypass from RESP to grant.
- Latency: accept at cycle T -> rsp_valid=1 in cycle T+2. Best-case throughput is 1 transaction per 3 cycles.
- Fairness: a continuously valid requester is granted within NUM_REQ transactions.
- rsp_err:
  - Set when req_shift[g] has popcount >=2.
  - The code is still forwarded unmodified.
  - All-zero and exactly-one-hot codes give rsp_err=0.
- A requester may drop req_valid without having been granted; no state is affected.
- Data and shift inputs are sampled only in the accept cycle. Later changes to them do not affect the in-flight transaction.

Test Plan:
- Reset, then idle for 5 cycles, no requests: all outputs 0. Assert rst while in RESP: next cycle rsp_valid=0 and state=IDLE.
- LEN=8, MAX_SHIFT_MAG=2, bench shifter with WRAP_AROUND=0 and SHIFT_AS_ONE_HOT=1.
  - Stimulus: requester 2 sends data[0:7]=0100_0000, shift[0:4]=00100, rsp_ready=1.
  - Required: req_ready=0100 at cycle T, rsp_valid at T+2, rsp_data=0100_0000, rsp_id=2.
- Same setup with shift[0:4]=01000 -> rsp_data[0:7]=0010_0000 and rsp_err=0. With shift=01010 -> rsp_err=1 and rsp_data equal to the bench shifter's output for that code.
- All 4 requesters held valid, rsp_ready=1 -> grant order 0,1,2,3,0,1 with one grant every 3 cycles.
- Backpressure: rsp_ready=0 for 6 cycles after rsp_valid -> outputs stable, req_ready all 0, no new grant. The grant occurs in the cycle after the handshake.
- Requester 1 changes req_data on the cycle after accept -> response reflects the originally sampled data.
